axi_lite_master_port: RTL



---
 rtl/AXI_define.sv | 18 +
 rtl/axi_outstanding_ctr.sv | 30 +++
 rtl/axi_lite_master_port.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/AXI_define.sv
// Shared AXI4-Lite definitions: response codes, direction-mode encoding and
// default bus widths used by every master port.
package AXI_define;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } axi_dir_e;

endpackage

// File: rtl/axi_outstanding_ctr.sv
// Saturating up/down counter of in-flight AXI transactions; simultaneous
// increment and decrement leave the count unchanged.
module axi_outstanding_ctr #(
    parameter int MAX = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         dec,
    output logic [$clog2(MAX+1)-1:0]     count,
    output logic                         full,
    output logic                         empty
);

    localparam int CNT_W = $clog2(MAX + 1);

    assign full  = (count == CNT_W'(MAX));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_master_port.sv
// AXI4-Lite master port: turns a core valid/ready request stream into AXI
// reads/writes, one direction in flight at a time so responses stay in order.
module axi_lite_master_port
    import AXI_define::*;
#(
    parameter int ADDR_W   = AXI_ADDR_BITS,
    parameter int DATA_W   = AXI_DATA_BITS,
    parameter int MAX_OUT  = 2,
    parameter int WRITE_EN = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             cnt_full;
    logic             cnt_empty;
    axi_dir_e         dir_reg;
    logic             ready_reg;
    logic             eff_write;
    logic             mode_ok;
    logic             ar_free;
    logic             aw_free;
    logic             w_free;
    logic             accept;
    logic             rd_hs;
    logic             wr_hs;
    logic             pending;

    assign eff_write = (WRITE_EN != 0) && req_write;
    assign mode_ok   = (dir_reg == IDLE) || ((dir_reg == WR) == eff_write);
    assign ar_free   = !ARVALID || ARREADY;
    assign aw_free   = !AWVALID || AWREADY;
    assign w_free    = !WVALID || WREADY;
    assign pending   = ARVALID || AWVALID || WVALID;

    // Combinational from the READY inputs so back-to-back issue needs no bubble.
    assign req_ready = ARESETn && !cnt_full && mode_ok &&
                       (eff_write ? (aw_free && w_free) : ar_free);
    assign accept    = req_valid && req_ready;

    assign rd_hs = RVALID && ready_reg && (dir_reg == RD) && !cnt_empty;
    assign wr_hs = (WRITE_EN != 0) && BVALID && ready_reg && (dir_reg == WR) && !cnt_empty;

    assign RREADY = ready_reg;
    assign BREADY = ready_reg;

    axi_outstanding_ctr #(
        .MAX   (MAX_OUT)
    ) u_ctr (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .inc   (accept),
        .dec   (rd_hs || wr_hs),
        .count (cnt),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            dir_reg   <= IDLE;
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
            if (accept) begin
                dir_reg <= eff_write ? WR : RD;
            end else if (dir_reg != IDLE && cnt_empty && !pending) begin
                dir_reg <= IDLE;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ARVALID <= 1'b0;
            ARADDR  <= '0;
        end else if (accept && !eff_write) begin
            ARVALID <= 1'b1;
            ARADDR  <= req_addr;
        end else if (ARREADY) begin
            ARVALID <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= rd_hs || wr_hs;
            rsp_write <= wr_hs;
            rsp_rdata <= (rd_hs && RRESP == AXI_RESP_OKAY) ? RDATA : '0;
            rsp_err   <= (rd_hs && RRESP != AXI_RESP_OKAY) ||
                         (wr_hs && BRESP != AXI_RESP_OKAY);
        end
    end

    generate
        if (WRITE_EN != 0) begin : g_write
            // AW and W retire independently; a new write only lands once both are free.
            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    AWVALID <= 1'b0;
                    WVALID  <= 1'b0;
                    AWADDR  <= '0;
                    WDATA   <= '0;
                    WSTRB   <= '0;
                end else if (accept && eff_write) begin
                    AWVALID <= 1'b1;
                    WVALID  <= 1'b1;
                    AWADDR  <= req_addr;
                    WDATA   <= req_wdata;
                    WSTRB   <= req_wstrb;
                end else begin
                    if (AWREADY) AWVALID <= 1'b0;
                    if (WREADY)  WVALID  <= 1'b0;
                end
            end
        end else begin : g_read_only
            logic unused_write;
            assign unused_write = ^{req_wdata, req_wstrb};
            assign AWVALID = 1'b0;
            assign WVALID  = 1'b0;
            assign AWADDR  = '0;
            assign WDATA   = '0;
            assign WSTRB   = '0;
        end
    endgenerate

    a_no_orphan_rsp: assert property (@(posedge ACLK) disable iff (!ARESETn)
        !((RVALID || BVALID) && cnt_empty));

endmodule
